// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: BCD MM:SS countdown engine with start/pause/resume.
// Ports: clk_100MHz, reset (sync, high), load + preset digits, start,
//   pause -> min_D1/min_D0/sec_D1/sec_D0 digits, running, done, expired.
module countdown_timer_bcd #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] preset_min_D1,
  input  logic [3:0] preset_min_D0,
  input  logic [3:0] preset_sec_D1,
  input  logic [3:0] preset_sec_D0,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_D1,
  output logic [3:0] min_D0,
  output logic [3:0] sec_D1,
  output logic [3:0] sec_D0,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST =
    CNT_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [3:0]       m1_q, m1_d;
  logic [3:0]       m0_q, m0_d;
  logic [3:0]       s1_q, s1_d;
  logic [3:0]       s0_q, s0_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;

  logic [3:0] m1_dec, m0_dec, s1_dec, s0_dec;
  logic       b0, b1, b2;
  logic       is_zero, dec_zero;

  function automatic logic [3:0] clamp(
    input logic [3:0] v,
    input logic [3:0] mx
  );
    return (v > mx) ? mx : v;
  endfunction

  // One-second decrement with BCD borrow chain.
  always_comb begin
    b0     = (s0_q == 4'd0);
    s0_dec = b0 ? 4'd9 : s0_q - 4'd1;
    b1     = b0 && (s1_q == 4'd0);
    s1_dec = s1_q;
    if (b0)
      s1_dec = (s1_q == 4'd0) ? 4'd5 : s1_q - 4'd1;
    b2     = b1 && (m0_q == 4'd0);
    m0_dec = m0_q;
    if (b1)
      m0_dec = (m0_q == 4'd0) ? 4'd9 : m0_q - 4'd1;
    m1_dec = m1_q;
    if (b2 && m1_q != 4'd0)
      m1_dec = m1_q - 4'd1;
    is_zero  = ({m1_q, m0_q, s1_q, s0_q} == 16'h0);
    dec_zero = ({m1_dec, m0_dec, s1_dec, s0_dec} == 16'h0);
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    done_d  = 1'b0;
    if (load && state_q != RUN) begin
      m1_d    = clamp(preset_min_D1, 4'd9);
      m0_d    = clamp(preset_min_D0, 4'd9);
      s1_d    = clamp(preset_sec_D1, 4'd5);
      s0_d    = clamp(preset_sec_D0, 4'd9);
      state_d = IDLE;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !is_zero) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (is_zero) begin
            state_d = DONE;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            m1_d  = m1_dec;
            m0_d  = m0_dec;
            s1_d  = s1_dec;
            s0_d  = s0_dec;
            if (dec_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        PAUSED: begin
          // Prescaler is kept so resume continues the partial second.
          if (start)
            state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      m1_q      <= 4'd0;
      m0_q      <= 4'd0;
      s1_q      <= 4'd0;
      s0_q      <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      m1_q      <= m1_d;
      m0_q      <= m0_d;
      s1_q      <= s1_d;
      s0_q      <= s0_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign min_D1  = m1_q;
  assign min_D0  = m0_q;
  assign sec_D1  = s1_q;
  assign sec_D0  = s0_q;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb_countdown_timer_bcd: scoreboard bench for countdown_timer_bcd.
// Reference model counts whole seconds; monitor compares every cycle.
module tb_countdown_timer_bcd;

  localparam int TD = 4;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset, load, start, pause;
  logic [3:0] p_m1, p_m0, p_s1, p_s0;
  logic [3:0] min_D1, min_D0, sec_D1, sec_D0;
  logic       running, done, expired;

  always #5 clk = ~clk;

  countdown_timer_bcd #(
    .TICK_DIV(TD),
    .CNT_W   (3)
  ) dut (
    .clk_100MHz   (clk),
    .reset        (reset),
    .load         (load),
    .preset_min_D1(p_m1),
    .preset_min_D0(p_m0),
    .preset_sec_D1(p_s1),
    .preset_sec_D0(p_s0),
    .start        (start),
    .pause        (pause),
    .min_D1       (min_D1),
    .min_D0       (min_D0),
    .sec_D1       (sec_D1),
    .sec_D0       (sec_D0),
    .running      (running),
    .done         (done),
    .expired      (expired)
  );

  int checks = 0;
  int errors = 0;

  logic [18:0] sbq[$];
  logic [18:0] mon_e;
  logic [18:0] got;

  assign got = {min_D1, min_D0, sec_D1, sec_D0,
                running, done, expired};

  // Model: time held as a plain count of seconds.
  int m_st   = S_IDLE;
  int m_t    = 0;
  int m_pre  = 0;
  bit m_done = 1'b0;

  function automatic int clampi(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [18:0] model_out();
    int mm;
    int ss;
    logic r, e;
    mm = m_t / 60;
    ss = m_t % 60;
    r  = (m_st == S_RUN);
    e  = (m_st == S_DONE);
    return {4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10), r, m_done, e};
  endfunction

  task automatic model(input bit r, input bit l,
                       input bit s, input bit p,
                       input logic [15:0] pv);
    m_done = 1'b0;
    if (r) begin
      m_st  = S_IDLE;
      m_t   = 0;
      m_pre = 0;
    end else if (l && m_st != S_RUN) begin
      m_t = (clampi(int'(pv[15:12]), 9) * 10
           + clampi(int'(pv[11:8]), 9)) * 60
          + clampi(int'(pv[7:4]), 5) * 10
          + clampi(int'(pv[3:0]), 9);
      m_st  = S_IDLE;
      m_pre = 0;
    end else begin
      case (m_st)
        S_IDLE:
          if (s && m_t != 0) begin
            m_st  = S_RUN;
            m_pre = 0;
          end
        S_RUN:
          if (p) m_st = S_PAUSE;
          else if (m_pre == TD - 1) begin
            m_pre = 0;
            m_t   = m_t - 1;
            if (m_t == 0) begin
              m_st   = S_DONE;
              m_done = 1'b1;
            end
          end else m_pre = m_pre + 1;
        S_PAUSE:
          if (s) m_st = S_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit l,
                      input bit s, input bit p,
                      input logic [15:0] pv);
    reset = r;
    load  = l;
    start = s;
    pause = p;
    {p_m1, p_m0, p_s1, p_s0} = pv;
    model(r, l, s, p, pv);
    sbq.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] dg,
                     input logic r, input logic d,
                     input logic e);
    logic [18:0] ex;
    ex = {dg, r, d, e};
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, ex);
    end
  endtask

  // Monitor: pop one expected vector per clock and compare.
  always @(posedge clk) begin
    #2;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if (got !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got=%h exp=%h",
                 $time, got, mon_e);
      end
    end
  end

  initial begin
    logic [15:0] pv;
    bit r, l, s, p;
    reset = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    {p_m1, p_m0, p_s1, p_s0} = 16'h0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0110);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(6);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("reset_mid_run", 16'h0000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    chk("pre_tick", 16'h0100, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("tick_0059", 16'h0059, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("tick_0058", 16'h0058, 1'b1, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0002);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(4);
    chk("tick_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("done_pulse", 16'h0000, 1'b0, 1'b1, 1'b1);
    idle(1);
    chk("done_drop", 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("start_in_done", 16'h0000, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    idle(10);
    chk("paused_hold", 16'h0010, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(1);
    chk("resume_1", 16'h0010, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("resume_2", 16'h0009, 1'b1, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h997C);
    chk("clamp", 16'h9959, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h997C);
    chk("load_start", 16'h9959, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("start_9959", 16'h9959, 1'b1, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("start_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("zero_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(4);
    chk("borrow_0959", 16'h0959, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005);
    chk("load_in_run", 16'h0959, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    chk("pause_wins", 16'h0959, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        pv = {8'h00, 4'($urandom_range(0, 1)),
              4'($urandom_range(0, 15))};
      else
        pv = 16'($urandom);
      step(r, l, s, p, pv);
    end

    idle(1);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
